// File: rtl/sonic_pkg.sv
// ============================================================================
// Module      : sonic_pkg
// Description : Shared types, FSM encoding and rotation helpers for the SONIC
//               round-key schedule.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sonic_pkg;

    typedef logic [63:0]  sonic_word_t;
    typedef logic [255:0] sonic_key_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } ks_state_e;

    localparam int KS_ROT_A = 3;
    localparam int KS_ROT_B = 11;

    function automatic sonic_word_t rotl(input sonic_word_t x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

endpackage

`default_nettype wire

// File: rtl/sonic_ks_step.sv
// ============================================================================
// Module      : sonic_ks_step
// Description : Combinational forward (and, with SONIC_KS_DEC_EN, inverse)
//               key-state step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sonic_ks_step
    import sonic_pkg::*;
(
    input  sonic_word_t k0_i,
    input  sonic_word_t k1_i,
    input  sonic_word_t k2_i,
    input  sonic_word_t k3_i,
    input  logic [7:0]  rc_i,
`ifdef SONIC_KS_DEC_EN
    input  logic        inv_i,
`endif
    output sonic_word_t k0_o,
    output sonic_word_t k1_o,
    output sonic_word_t k2_o,
    output sonic_word_t k3_o
);

    sonic_word_t w_rc;

    assign w_rc = {56'b0, rc_i};

    always_comb begin
        k0_o = k1_i;
        k1_o = k2_i;
        k2_o = k3_i;
        k3_o = k0_i ^ rotl(k3_i, KS_ROT_A) ^ rotl(k2_i, KS_ROT_B) ^ w_rc;
`ifdef SONIC_KS_DEC_EN
        // Undo a forward step: the word shifted out is recovered from the new k3.
        if (inv_i) begin
            k1_o = k0_i;
            k2_o = k1_i;
            k3_o = k2_i;
            k0_o = k3_i ^ rotl(k2_i, KS_ROT_A) ^ rotl(k1_i, KS_ROT_B) ^ w_rc;
        end
`endif
    end

endmodule

`default_nettype wire

// File: rtl/sonic_key_schedule.sv
// ============================================================================
// Module      : sonic_key_schedule
// Description : Sequential SONIC round-key generator with valid/ready output.
//               Define SONIC_KS_DEC_EN to build reverse (decrypt) key order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sonic_key_schedule
    import sonic_pkg::*;
#(
    parameter int ROUNDS = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  sonic_key_t  key_in_i,
`ifdef SONIC_KS_DEC_EN
    input  logic        dec_i,
`endif
    output logic        busy_o,
    output logic        rk_valid_o,
    input  logic        rk_ready_i,
    output sonic_word_t rk_o,
    output logic [7:0]  rk_idx_o,
    output logic        done_o
);

    localparam logic [7:0] c_last_idx = 8'(ROUNDS - 1);
    localparam logic [7:0] c_pre_last = 8'(ROUNDS - 2);

    ks_state_e   state_q, state_d;
    logic [7:0]  i_q, i_d;
    sonic_word_t k0_q, k1_q, k2_q, k3_q;
    sonic_word_t k0_d, k1_d, k2_d, k3_d;
    sonic_word_t w_k0_nx, w_k1_nx, w_k2_nx, w_k3_nx;
    logic [7:0]  w_rc;

`ifdef SONIC_KS_DEC_EN
    logic dec_q, dec_d;
    logic w_inv;

    // PRE always runs forward; only emission in decrypt order walks backwards.
    assign w_inv = dec_q && (state_q == ST_EMIT);
    assign w_rc  = w_inv ? (i_q - 8'd1) : i_q;
`else
    assign w_rc  = i_q;
`endif

    sonic_ks_step u_step (
        .k0_i  (k0_q),
        .k1_i  (k1_q),
        .k2_i  (k2_q),
        .k3_i  (k3_q),
        .rc_i  (w_rc),
`ifdef SONIC_KS_DEC_EN
        .inv_i (w_inv),
`endif
        .k0_o  (w_k0_nx),
        .k1_o  (w_k1_nx),
        .k2_o  (w_k2_nx),
        .k3_o  (w_k3_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= 8'd0;
            k0_q    <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            k3_q    <= '0;
`ifdef SONIC_KS_DEC_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            k3_q    <= k3_d;
`ifdef SONIC_KS_DEC_EN
            dec_q   <= dec_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        k0_d    = k0_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        k3_d    = k3_q;
`ifdef SONIC_KS_DEC_EN
        dec_d   = dec_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    {k3_d, k2_d, k1_d, k0_d} = key_in_i;
                    i_d     = 8'd0;
                    state_d = ST_EMIT;
`ifdef SONIC_KS_DEC_EN
                    dec_d = dec_i;
                    if (dec_i) state_d = ST_PRE;
`endif
                end
            end
`ifdef SONIC_KS_DEC_EN
            ST_PRE: begin
                {k3_d, k2_d, k1_d, k0_d} = {w_k3_nx, w_k2_nx, w_k1_nx, w_k0_nx};
                i_d = i_q + 8'd1;
                if (i_q == c_pre_last) state_d = ST_EMIT;
            end
`endif
            ST_EMIT: begin
                if (rk_ready_i) begin
`ifdef SONIC_KS_DEC_EN
                    if (dec_q) begin
                        if (i_q == 8'd0) begin
                            state_d = ST_DONE;
                        end else begin
                            {k3_d, k2_d, k1_d, k0_d} = {w_k3_nx, w_k2_nx, w_k1_nx, w_k0_nx};
                            i_d = i_q - 8'd1;
                        end
                    end else
`endif
                    begin
                        if (i_q == c_last_idx) begin
                            state_d = ST_DONE;
                        end else begin
                            {k3_d, k2_d, k1_d, k0_d} = {w_k3_nx, w_k2_nx, w_k1_nx, w_k0_nx};
                            i_d = i_q + 8'd1;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != ST_IDLE);
        rk_valid_o = (state_q == ST_EMIT);
        done_o     = (state_q == ST_DONE);
        rk_o       = k0_q;
        rk_idx_o   = i_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_sonic_key_schedule.sv
// ============================================================================
// Module      : tb_sonic_key_schedule
// Description : Randomized self-checking bench for sonic_key_schedule against
//               a word-recurrence reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sonic_key_schedule;

    localparam int ROUNDS = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic [255:0] key_in_i = '0;
    logic         dec_i = 1'b0;
    logic         busy_o, rk_valid_o, done_o;
    logic         rk_ready_i = 1'b0;
    logic [63:0]  rk_o;
    logic [7:0]   rk_idx_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_rk [0:ROUNDS-1];

    always #5 clk = ~clk;

    sonic_key_schedule #(.ROUNDS(ROUNDS)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .key_in_i   (key_in_i),
`ifdef SONIC_KS_DEC_EN
        .dec_i      (dec_i),
`endif
        .busy_o     (busy_o),
        .rk_valid_o (rk_valid_o),
        .rk_ready_i (rk_ready_i),
        .rk_o       (rk_o),
        .rk_idx_o   (rk_idx_o),
        .done_o     (done_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rot64(input logic [63:0] x, input int n);
        logic [127:0] t;
        t = {x, x} << n;
        return t[127:64];
    endfunction

    // Round keys as a sliding window over w[j+4] = w[j] ^ rot(w[j+3],3) ^ rot(w[j+2],11) ^ j.
    task automatic build_model(input logic [255:0] key);
        logic [63:0] w [0:ROUNDS+3];
        for (int j = 0; j < 4; j++) w[j] = key[64*j +: 64];
        for (int j = 0; j < ROUNDS; j++)
            w[j+4] = w[j] ^ rot64(w[j+3], 3) ^ rot64(w[j+2], 11) ^ 64'(j);
        for (int j = 0; j < ROUNDS; j++) exp_rk[j] = w[j];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered at a sample point in IDLE; returns at the IDLE sample after DONE.
    task automatic run_seq(input logic [255:0] key, input logic dec, input bit rand_ready,
                           input bit noise_start);
        int n;
        int cyc;
        logic rdy;
        build_model(key);
        key_in_i = key;
        dec_i    = dec;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        check("busy_after_start", 64'(busy_o), 64'd1);
        if (dec) begin
            for (int p = 0; p < ROUNDS - 1; p++) begin
                check("pre_valid_low", 64'(rk_valid_o), 64'd0);
                tick();
            end
        end
        n = 0;
        cyc = 0;
        while (n < ROUNDS && cyc < 400) begin
            check("rk_valid", 64'(rk_valid_o), 64'd1);
            check("rk", rk_o, dec ? exp_rk[ROUNDS-1-n] : exp_rk[n]);
            check("rk_idx", 64'(rk_idx_o), dec ? 64'(ROUNDS-1-n) : 64'(n));
            check("done_low", 64'(done_o), 64'd0);
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            rk_ready_i = rdy;
            if (noise_start) begin
                start_i  = 1'($urandom_range(0, 1));
                key_in_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                dec_i    = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
            if (rdy) n++;
        end
        if (n < ROUNDS) check("emit_timeout", 64'(n), 64'(ROUNDS));
        start_i = 1'b0;
        rk_ready_i = 1'b0;
        check("done_pulse", 64'(done_o), 64'd1);
        check("done_valid_low", 64'(rk_valid_o), 64'd0);
        check("done_busy", 64'(busy_o), 64'd1);
        tick();
        check("idle_done_low", 64'(done_o), 64'd0);
        check("idle_busy_low", 64'(busy_o), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_valid"}, 64'(rk_valid_o), 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
        check({tag, "_rk"}, rk_o, 64'd0);
        check({tag, "_idx"}, 64'(rk_idx_o), 64'd0);
    endtask

    initial begin
        logic [255:0] k;
        logic d;
        int guard;
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        run_seq({64'd4, 64'd3, 64'd2, 64'd1}, 1'b0, 1'b0, 1'b0);
        check("enc_last_key_held", rk_o, 64'h1821);
`ifdef SONIC_KS_DEC_EN
        run_seq({64'd4, 64'd3, 64'd2, 64'd1}, 1'b1, 1'b0, 1'b0);
        check("dec_last_key_held", rk_o, 64'd1);
`endif

        for (int t = 0; t < 12; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
`ifdef SONIC_KS_DEC_EN
            d = 1'($urandom_range(0, 1));
`else
            d = 1'b0;
`endif
            run_seq(k, d, 1'b1, 1'b1);
        end

        // Reset while emitting rk_2.
        key_in_i   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        dec_i      = 1'b0;
        start_i    = 1'b1;
        rk_ready_i = 1'b1;
        tick();
        start_i = 1'b0;
        guard = 0;
        while (rk_idx_o != 8'd2 && guard < 20) begin
            tick();
            guard++;
        end
        check("reach_idx2", 64'(rk_idx_o), 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rk_ready_i = 1'b0;
        check_reset_outputs("midrst");
        tick();
        check("midrst_no_done", 64'(done_o), 64'd0);
        run_seq({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                1'b0, 1'b1, 1'b0);

        // rst and start together: reset wins.
        rst     = 1'b1;
        start_i = 1'b1;
        tick();
        rst     = 1'b0;
        start_i = 1'b0;
        check("rst_start_busy", 64'(busy_o), 64'd0);
        check("rst_start_valid", 64'(rk_valid_o), 64'd0);
        tick();
        check("rst_start_busy2", 64'(busy_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
